// File: rtl/tse_cfg_pkg.sv
// ----------------------------------------------------------------------------
// tse_cfg_pkg
// Shared types and constants for the TSE MAC configuration sequencer.
//   state_t    : sequencer FSM states
//   err_t      : error code reported on err_code
//   CMD_CONFIG, MAC_0, MAC_1 : default TSE register addresses
//   idx_width  : width of an entry index for a table of n entries (min 1 bit)
// ----------------------------------------------------------------------------
package tse_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_NEXT  = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_TIMEOUT  = 2'd1,
        ERR_MISMATCH = 2'd2
    } err_t;

    localparam logic [7:0] CMD_CONFIG = 8'h02;
    localparam logic [7:0] MAC_0      = 8'h03;
    localparam logic [7:0] MAC_1      = 8'h04;

    // A one-entry table still needs a one-bit index.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tse_cfg_timeout.sv
// ----------------------------------------------------------------------------
// tse_cfg_timeout
// Wait-request watchdog: a down-counter reloaded with TIMEOUT by clr and
// decremented by en. expired is asserted during the enabled cycle that
// would use up the last tolerated count, so the owner can abort on that
// same clock edge (exactly TIMEOUT stalled cycles are observed).
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clr      : reload the counter (no stall in progress)
//   en       : one stalled cycle of the pending command
//   expired  : stall budget exhausted this cycle
// ----------------------------------------------------------------------------
module tse_cfg_timeout #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] remain_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remain_reg <= '0;
        end else if (clr) begin
            remain_reg <= CW'(TIMEOUT);
        end else if (en && (remain_reg != '0)) begin
            remain_reg <= remain_reg - CW'(1);
        end
    end

    assign expired = en && (remain_reg == CW'(1));

endmodule

// File: rtl/tse_cfg_seq.sv
// ----------------------------------------------------------------------------
// tse_cfg_seq
// Writes a table of up to N_ENTRIES address/data pairs into the TSE MAC
// register port after a start pulse, with wait-request timeout detection
// and error reporting.
// Optional feature, macro TSE_CFG_READBACK_EN: each accepted write is
// followed by a read of the same address and the returned data is compared
// with what was written. Without the macro reg_rd is held at 0.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   start        : single-cycle pulse, ignored while busy
//   cfg_count    : number of valid entries, latched at start, saturated
//   cfg_addr     : packed addresses, entry i at [i*ADDR_W +: ADDR_W]
//   cfg_data     : packed data, entry i at [i*DATA_W +: DATA_W]
//   reg_data_out : MAC read data
//   reg_busy     : MAC wait-request
//   reg_data_in, reg_addr, reg_rd, reg_wr : MAC command outputs
//   busy, done, error, err_code, err_index : sequence status
// ----------------------------------------------------------------------------
module tse_cfg_seq
    import tse_cfg_pkg::*;
#(
    parameter  int unsigned N_ENTRIES = 8,
    parameter  int unsigned ADDR_W    = 8,
    parameter  int unsigned DATA_W    = 32,
    parameter  int unsigned TIMEOUT   = 1023,
    localparam int unsigned CNT_W     = $clog2(N_ENTRIES + 1),
    localparam int unsigned IDX_W     = idx_width(N_ENTRIES)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [CNT_W-1:0]            cfg_count,
    input  logic [N_ENTRIES*ADDR_W-1:0] cfg_addr,
    input  logic [N_ENTRIES*DATA_W-1:0] cfg_data,
    input  logic [DATA_W-1:0]           reg_data_out,
    input  logic                        reg_busy,
    output logic [DATA_W-1:0]           reg_data_in,
    output logic [ADDR_W-1:0]           reg_addr,
    output logic                        reg_rd,
    output logic                        reg_wr,
    output logic                        busy,
    output logic                        done,
    output logic                        error,
    output logic [1:0]                  err_code,
    output logic [IDX_W-1:0]            err_index
);

    state_t            state_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [IDX_W-1:0]  index_reg;

    logic [ADDR_W-1:0] addr_tbl [N_ENTRIES];
    logic [DATA_W-1:0] data_tbl [N_ENTRIES];

    genvar gi;
    generate
        for (gi = 0; gi < N_ENTRIES; gi++) begin : g_unpack
            assign addr_tbl[gi] = cfg_addr[gi*ADDR_W +: ADDR_W];
            assign data_tbl[gi] = cfg_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    logic             cmd_pending;
    logic             cmd_accept;
    logic             cmd_stall;
    logic             tmo_expired;
    logic [CNT_W-1:0] count_sat;
    logic [IDX_W-1:0] index_inc;
    logic             last_entry;

    assign cmd_pending = reg_wr | reg_rd;
    assign cmd_accept  = cmd_pending & ~reg_busy;
    assign cmd_stall   = cmd_pending & reg_busy;
    assign count_sat   = (cfg_count > CNT_W'(N_ENTRIES)) ? CNT_W'(N_ENTRIES) : cfg_count;
    assign index_inc   = index_reg + IDX_W'(1);
    assign last_entry  = (CNT_W'(index_reg) + CNT_W'(1)) == count_reg;

    // Any cycle that is not a stall (idle, or the acceptance cycle) reloads
    // the watchdog, so each write and each read gets a fresh budget.
    tse_cfg_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (~cmd_stall),
        .en      (cmd_stall),
        .expired (tmo_expired)
    );

`ifndef TSE_CFG_READBACK_EN
    logic unused_rd_data;
    assign unused_rd_data = ^reg_data_out;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            count_reg   <= '0;
            index_reg   <= '0;
            reg_data_in <= '0;
            reg_addr    <= '0;
            reg_rd      <= 1'b0;
            reg_wr      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            err_code    <= ERR_NONE;
            err_index   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        count_reg <= count_sat;
                        index_reg <= '0;
                        done      <= 1'b0;
                        error     <= 1'b0;
                        err_code  <= ERR_NONE;
                        if (count_sat == '0) begin
                            // Empty table: finish without issuing anything.
                            state_reg <= ST_DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            state_reg   <= ST_WRITE;
                            busy        <= 1'b1;
                            reg_wr      <= 1'b1;
                            reg_addr    <= addr_tbl[0];
                            reg_data_in <= data_tbl[0];
                        end
                    end
                end

                ST_WRITE: begin
                    if (cmd_accept) begin
                        reg_wr <= 1'b0;
`ifdef TSE_CFG_READBACK_EN
                        // Address and data stay registered; the data is the
                        // reference for the read-back compare.
                        state_reg <= ST_READ;
                        reg_rd    <= 1'b1;
`else
                        state_reg <= ST_NEXT;
`endif
                    end else if (tmo_expired) begin
                        state_reg <= ST_ERROR;
                        reg_wr    <= 1'b0;
                        busy      <= 1'b0;
                        error     <= 1'b1;
                        err_code  <= ERR_TIMEOUT;
                        err_index <= index_reg;
                    end
                end

`ifdef TSE_CFG_READBACK_EN
                ST_READ: begin
                    if (cmd_accept) begin
                        reg_rd <= 1'b0;
                        if (reg_data_out != reg_data_in) begin
                            state_reg <= ST_ERROR;
                            busy      <= 1'b0;
                            error     <= 1'b1;
                            err_code  <= ERR_MISMATCH;
                            err_index <= index_reg;
                        end else begin
                            state_reg <= ST_NEXT;
                        end
                    end else if (tmo_expired) begin
                        state_reg <= ST_ERROR;
                        reg_rd    <= 1'b0;
                        busy      <= 1'b0;
                        error     <= 1'b1;
                        err_code  <= ERR_TIMEOUT;
                        err_index <= index_reg;
                    end
                end
`endif

                ST_NEXT: begin
                    if (last_entry) begin
                        state_reg <= ST_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        state_reg   <= ST_WRITE;
                        index_reg   <= index_inc;
                        reg_wr      <= 1'b1;
                        reg_addr    <= addr_tbl[index_inc];
                        reg_data_in <= data_tbl[index_inc];
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                    reg_wr    <= 1'b0;
                    reg_rd    <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tse_cfg_seq.sv
// ----------------------------------------------------------------------------
// tb_tse_cfg_seq
// Bench for tse_cfg_seq. A MAC model drives reg_busy/reg_data_out, a monitor
// logs every accepted command, and each sequence is compared against the
// command list, final status and latency expected from the table.
// ----------------------------------------------------------------------------
module tb_tse_cfg_seq;
    import tse_cfg_pkg::*;

    localparam int N   = 8;
    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int TMO = 8;
    localparam int CW  = $clog2(N + 1);
`ifdef TSE_CFG_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif
    localparam int K = RB ? 3 : 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [CW-1:0]   cfg_count;
    logic [N*AW-1:0] cfg_addr;
    logic [N*DW-1:0] cfg_data;
    logic [DW-1:0]   reg_data_out;
    logic            reg_busy;
    logic [DW-1:0]   reg_data_in;
    logic [AW-1:0]   reg_addr;
    logic            reg_rd;
    logic            reg_wr;
    logic            busy;
    logic            done;
    logic            error;
    logic [1:0]      err_code;
    logic [2:0]      err_index;

    tse_cfg_seq #(
        .N_ENTRIES (N),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .TIMEOUT   (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cfg_count    (cfg_count),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .reg_data_out (reg_data_out),
        .reg_busy     (reg_busy),
        .reg_data_in  (reg_data_in),
        .reg_addr     (reg_addr),
        .reg_rd       (reg_rd),
        .reg_wr       (reg_wr),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .err_code     (err_code),
        .err_index    (err_index)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference table and MAC model state ----------------
    logic [AW-1:0] t_addr [N];
    logic [DW-1:0] t_data [N];
    logic [DW-1:0] mem    [256];
    logic [40:0]   obs_q[$];
    logic [40:0]   exp_q[$];
    logic [40:0]   held;
    bit            hold_valid = 1'b0;
    int wr_seen = 0, rd_seen = 0, stall = 0, run = 0, max_run = 0;
    int done_cyc = -1, s_cyc = 0;
    int busy_pct = 0, hold_target = -1, hold_cnt = 0, stuck_target = -1, rb_run = 0;
    bit            corrupt = 1'b0;
    logic [AW-1:0] corrupt_addr = 8'h00;
    logic [DW-1:0] corrupt_val = 32'h0;

    // MAC model: decides wait-request for the current cycle and returns the
    // last written data for the presented address.
    initial begin
        bit b;
        reg_busy     = 1'b0;
        reg_data_out = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reg_wr || reg_rd) begin
                if (stuck_target >= 0 && reg_wr && wr_seen == stuck_target)
                    b = 1'b1;
                else if (hold_cnt > 0 && reg_wr && wr_seen == hold_target) begin
                    b = 1'b1;
                    hold_cnt--;
                end else
                    b = (rb_run < TMO - 1) && ($urandom_range(99) < busy_pct);
                rb_run = b ? rb_run + 1 : 0;
            end else begin
                b = ($urandom_range(99) < busy_pct);
                rb_run = 0;
            end
            reg_busy     = b;
            reg_data_out = (corrupt && reg_addr == corrupt_addr) ? corrupt_val : mem[reg_addr];
        end
    end

    // Monitor: command stability while stalled, accepted-command log.
    always @(negedge clk) begin
        if (rst) begin
            hold_valid = 1'b0;
            run = 0;
        end else begin
            if (done && done_cyc < 0) done_cyc = cyc;
            if (reg_wr || reg_rd) begin
                check("one_strobe", 64'(reg_wr & reg_rd), 64'd0);
                if (hold_valid)
                    check("held_cmd", 64'({reg_rd, reg_addr, reg_data_in}), 64'(held));
                run++;
                if (!reg_busy) begin
                    if (run > max_run) max_run = run;
                    run = 0;
                    hold_valid = 1'b0;
                    if (reg_wr) begin
                        obs_q.push_back({1'b0, reg_addr, reg_data_in});
                        mem[reg_addr] = reg_data_in;
                        wr_seen++;
                    end else begin
                        obs_q.push_back({1'b1, reg_addr, 32'h0});
                        rd_seen++;
                    end
                end else begin
                    hold_valid = 1'b1;
                    held = {reg_rd, reg_addr, reg_data_in};
                    stall++;
                end
            end else begin
                hold_valid = 1'b0;
            end
        end
    end

    task automatic load_directed();
        for (int i = 0; i < N; i++) begin
            t_addr[i] = 8'($urandom);
            t_data[i] = $urandom;
        end
        t_addr[0] = CMD_CONFIG; t_data[0] = 32'h0000_0043;
        t_addr[1] = MAC_0;      t_data[1] = 32'h1122_3344;
        t_addr[2] = MAC_1;      t_data[2] = 32'h0000_5566;
    endtask

    task automatic clear_log();
        obs_q.delete();
        wr_seen = 0; rd_seen = 0; stall = 0; run = 0; max_run = 0;
        hold_valid = 1'b0;
    endtask

    task automatic pack_cfg();
        for (int i = 0; i < N; i++) begin
            cfg_addr[i*AW +: AW] = t_addr[i];
            cfg_data[i*DW +: DW] = t_data[i];
        end
    endtask

    task automatic run_seq(input int cnt, input bit mid_start);
        bit fin = 1'b0;
        pack_cfg();
        clear_log();
        @(posedge clk); #1;
        cfg_count = CW'(cnt);
        start = 1'b1;
        s_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        done_cyc = -1;
        for (int c = 0; c < 3000 && !fin; c++) begin
            @(negedge clk);
            if (mid_start && c == 2 && busy) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            if (done || error) fin = 1'b1;
        end
        if (!fin) check("seq_wait", 64'd0, 64'd1);
        repeat (2) @(negedge clk);
    endtask

    // exp_err: 0 success, 1 timeout at write of entry exp_idx, 2 mismatch.
    task automatic verify(input string nm, input int cnt, input int exp_err,
                          input int exp_idx, input bit chk_lat);
        int n;
        int len;
        logic [3:0] exp_st;
        n = (cnt > N) ? N : cnt;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({1'b0, t_addr[i], t_data[i]});
            if (RB) exp_q.push_back({1'b1, t_addr[i], 32'h0});
        end
        if (exp_err == 1)      len = exp_idx * (RB ? 2 : 1);
        else if (exp_err == 2) len = exp_idx * 2 + 2;
        else                   len = exp_q.size();
        check({nm, "_cmds"}, 64'(obs_q.size()), 64'(len));
        for (int i = 0; i < len && i < obs_q.size(); i++)
            check({nm, "_cmd"}, 64'(obs_q[i]), 64'(exp_q[i]));
        exp_st = {exp_err == 0, exp_err != 0, 2'(exp_err)};
        check({nm, "_status"}, 64'({done, error, err_code}), 64'(exp_st));
        check({nm, "_idle"}, 64'({busy, reg_wr, reg_rd}), 64'd0);
        if (exp_err != 0) check({nm, "_err_index"}, 64'(err_index), 64'(exp_idx));
        if (chk_lat) check({nm, "_latency"}, 64'(done_cyc - s_cyc), 64'(K * n + 1 + stall));
        $display("seq %s: count=%0d cmds=%0d done=%0b error=%0b code=%0d idx=%0d lat=%0d stall=%0d",
                 nm, cnt, obs_q.size(), done, error, err_code, err_index, done_cyc - s_cyc, stall);
    endtask

    initial begin
        bit fin;
        rst = 1'b1; start = 1'b0; cfg_count = '0; cfg_addr = '0; cfg_data = '0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_status", 64'({busy, done, error, err_code, reg_wr, reg_rd, err_index, reg_addr}), 64'd0);
        check("rst_wdata", 64'(reg_data_in), 64'd0);
        rst = 1'b0;

        // Directed table, no wait-request.
        load_directed();
        run_seq(3, 1'b0);
        verify("basic", 3, 0, 0, 1'b1);
        check("basic_pulse", 64'(max_run), 64'd1);
        if (!RB) check("no_rd", 64'(rd_seen), 64'd0);

        // Four stalled cycles on entry 1.
        hold_target = 1; hold_cnt = 4;
        run_seq(3, 1'b0);
        verify("hold4", 3, 0, 0, 1'b1);
        check("hold4_len", 64'(max_run), 64'd5);
        hold_target = -1; hold_cnt = 0;

        // Wait-request stuck on entry 2.
        stuck_target = 2;
        run_seq(3, 1'b0);
        verify("timeout", 3, 1, 2, 1'b0);
        check("timeout_run", 64'(run), 64'(TMO));
        stuck_target = -1;

        // Empty table, then a restart attempt while a sequence is running.
        run_seq(0, 1'b0);
        verify("empty", 0, 0, 0, 1'b1);
        hold_target = 0; hold_cnt = 4;
        run_seq(3, 1'b1);
        verify("restart", 3, 0, 0, 1'b1);
        hold_target = -1; hold_cnt = 0;

        // Oversized count saturates to the table depth.
        for (int i = 0; i < N; i++) begin t_addr[i] = 8'($urandom); t_data[i] = $urandom; end
        run_seq(9, 1'b0);
        verify("saturate", 9, 0, 0, 1'b1);

`ifdef TSE_CFG_READBACK_EN
        load_directed();
        corrupt = 1'b1; corrupt_addr = 8'h02; corrupt_val = 32'h0000_0040;
        run_seq(3, 1'b0);
        verify("rb_mismatch", 3, 2, 0, 1'b0);
        corrupt = 1'b0;
`endif

        // Reset while a write is pending.
        load_directed();
        pack_cfg();
        clear_log();
        hold_target = 1; hold_cnt = 1000;
        @(posedge clk); #1;
        cfg_count = CW'(3); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        fin = 1'b0;
        for (int c = 0; c < 200 && !fin; c++) begin
            @(negedge clk);
            if (reg_wr && wr_seen == 1) fin = 1'b1;
        end
        check("rst_reach", 64'(fin), 64'd1);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check("rst_async", 64'({reg_wr, reg_rd, busy, done, error}), 64'd0);
        hold_target = -1; hold_cnt = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_seq(3, 1'b0);
        verify("after_rst", 3, 0, 0, 1'b1);

        // Randomized tables, counts and wait-request traffic.
        for (int it = 0; it < 12; it++) begin
            int cnt;
            for (int i = 0; i < N; i++) begin t_addr[i] = 8'($urandom); t_data[i] = $urandom; end
            cnt = $urandom_range(0, 10);
            busy_pct = $urandom_range(0, 60);
            run_seq(cnt, (it % 3) == 0);
            verify("rand", cnt, 0, 0, 1'b1);
        end
        busy_pct = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tse_cfg_seq.md
Name: tse_cfg_seq

Overview:
Parametrised sequencer that writes a table of up to N_ENTRIES address/data pairs into the TSE MAC control register port. It runs after a start pulse and replaces the fixed MAC-lo/MAC-hi/config write sequence. It adds a start/done handshake, wait-request timeout detection, error reporting, and optional read-back verification. It sits between board bring-up logic and the MAC's 32-bit register interface.

Parameters:
N_ENTRIES, 8, table depth (1..256)
ADDR_W, 8, MAC register address width
DATA_W, 32, MAC register data width
TIMEOUT, 1023, maximum consecutive reg_busy cycles tolerated per command (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  single-cycle pulse; begins sequence
cfg_count  in  $clog2(N_ENTRIES+1)  number of valid entries, latched at start
cfg_addr  in  N_ENTRIES*ADDR_W  packed addresses, entry i at [i*ADDR_W +: ADDR_W]
cfg_data  in  N_ENTRIES*DATA_W  packed data, same packing
reg_data_out  in  DATA_W  MAC read data
reg_busy  in  1  MAC wait-request
reg_data_in  out  DATA_W  write data to MAC
reg_addr  out  ADDR_W  register address to MAC
reg_rd  out  1  read strobe
reg_wr  out  1  write strobe
busy  out  1  sequence in progress
done  out  1  sequence completed without error; held until next start
error  out  1  sequence aborted; held until next start
err_code  out  2  0 none, 1 timeout, 2 read-back mismatch
err_index  out  $clog2(N_ENTRIES)  entry index that failed

Behaviour:
- Reset: state IDLE. All outputs 0. Index and timeout counter 0.
- All outputs are registered. reg_addr, reg_data_in, reg_wr and reg_rd change only on clk edges.
- Command handshake: a command is acceptance-pending while reg_wr or reg_rd is 1. It is accepted on the first cycle with reg_busy=0. The command and its address/data are held stable until accepted. Strobes drop on the cycle after acceptance.
- Read data: sampled from reg_data_out in the acceptance cycle.
- States: IDLE, WRITE, READ (only when feature is enabled), NEXT, DONE, ERROR.
- IDLE/DONE/ERROR + start:
  - Latch cfg_count. Clear done, error and err_code. Index = 0. Set busy.
  - If cfg_count==0, go to DONE (done=1 one cycle after start). Otherwise go to WRITE.
- WRITE: drive entry[index]. On acceptance, go to READ if the feature is enabled, else go to NEXT.
- NEXT:
  - If index==count-1, go to DONE.
  - Otherwise index++ and go to WRITE.
  - This gives one idle cycle between commands.
- DONE: busy=0, done=1.
- Timeout: the counter resets on each new command and increments on every pending cycle with reg_busy=1. When the counter reaches TIMEOUT and busy is still high, drop the strobe, err_code=1, err_index=index, go to ERROR.
- ERROR: busy=0, error=1, remaining entries skipped.
- start while busy=1 is ignored.
- cfg_addr and cfg_data must be stable while busy. Values beyond cfg_count-1 are don't-care.
- cfg_count > N_ENTRIES is saturated to N_ENTRIES.
- Reset mid-command drops the strobes asynchronously. No resume.
- Minimum latency with reg_busy=0 and no read-back: done rises 2*count+1 cycles after the start cycle.

Optional Feature:
Macro TSE_CFG_READBACK_EN.
- Defined: after each accepted write, READ issues reg_rd to the same address. On acceptance, reg_data_out is compared with the written data.
  - Mismatch: err_code=2, err_index=index, go to ERROR.
  - Match: go to NEXT.
  - The read is covered by the same timeout. Latency becomes 3*count+1.
- Undefined: READ state and compare logic are absent. reg_rd is tied 0. err_code never equals 2.

Decomposition:
- Package tse_cfg_pkg holds:
  - state_t enum
  - err_t enum (ERR_NONE=0, ERR_TIMEOUT=1, ERR_MISMATCH=2)
  - default TSE register address constants (CMD_CONFIG=8'h02, MAC_0=8'h03, MAC_1=8'h04)
- One sub-module, tse_cfg_timeout: a parametrised down-counter with clear and enable that flags expiry. It is reused for the write and read commands.

Test Plan:
- count=3, entries {02:0000_0043, 03:1122_3344, 04:0000_5566}, reg_busy=0 -> three writes in order, reg_wr pulses 1 cycle each, done=1 at cycle 7 after start, error=0.
- Same table, reg_busy high for 4 cycles on entry 1 -> address/data held stable for 5 cycles, one acceptance, sequence completes with done=1.
- TIMEOUT=8, reg_busy stuck high on entry 2 of 3 -> reg_wr drops after 8 busy cycles, error=1, err_code=1, err_index=2, done=0.
- start with cfg_count=0 -> no strobes, done=1 the next cycle. A second start pulse while busy is ignored, with no extra writes.
- With TSE_CFG_READBACK_EN: model returns 0000_0040 for address 02 -> err_code=2, err_index=0, no further writes. Correct model -> write/read alternate, done at 3*count+1.
- Assert rst during a pending write -> reg_wr, busy and done drop immediately. After release, a start reruns the full table from index 0.
